// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: state encoding for the
// rate decoder, counter ceiling and the common spike/current word width.
package snn_pkg;

    localparam int SNN_W = 8;

    localparam logic [SNN_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [SNN_W-1:0] sat_inc(input logic [SNN_W-1:0] v);
        return (v == CNT_MAX) ? v : v + SNN_W'(1);
    endfunction

endpackage

// File: rtl/spike_sync.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// rising-edge detector. A rise on the pin becomes a one-cycle evt pulse
// three clock edges later; a level held high yields a single pulse.
module spike_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Metastability stages, one history stage and the registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            evt   <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            sync3 <= sync2;
            evt   <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a raw spike train into a windowed firing rate and the most recent
// inter-spike interval, both in prescaled time ticks.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | decoding stopped, counters held clear, outputs hold last values
//   RUN   | prescaler ticking, window and ISI counters active
//
// The window length is kept as a down-counter loaded from window_len at each
// window start; the window closes on the tick that finds it at 1.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int PRESCALE = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [SNN_W-1:0] window_len,
    output logic [SNN_W-1:0] rate,
    output logic             rate_valid,
    output logic             ovf,
    output logic [SNN_W-1:0] isi,
    output logic             isi_valid
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);

    dec_state_t       state;
    dec_state_t       next_state;
    logic             spike_evt;
    logic [PW-1:0]    presc;
    logic             tick;
    logic             win_end;
    logic [SNN_W-1:0] win_rem;
    logic [SNN_W-1:0] spike_cnt;
    logic             ovf_pend;
    logic [SNN_W-1:0] cnt_next;
    logic             ovf_next;
    logic [SNN_W-1:0] isi_cnt;
    logic             have_prev;

    spike_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spike_in),
        .evt   (spike_evt)
    );

    // Prescaler counts down from PRESCALE-1, so its terminal count is the wrap.
    assign tick    = (state == RUN) && (presc == '0);
    assign win_end = tick && (win_rem == SNN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start on enable with a non-zero window, stop on disable or
    // when a window closes while window_len reads 0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable && (window_len != '0)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (win_end && (window_len == '0)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Spike count including this cycle's event, and whether it overflowed.
    always_comb begin
        cnt_next = spike_cnt;
        ovf_next = ovf_pend;
        if (spike_evt) begin
            cnt_next = sat_inc(spike_cnt);
            if (spike_cnt == CNT_MAX) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Prescaler, window counter, ISI counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            win_rem    <= '0;
            spike_cnt  <= '0;
            ovf_pend   <= 1'b0;
            isi_cnt    <= '0;
            have_prev  <= 1'b0;
            rate       <= '0;
            rate_valid <= 1'b0;
            ovf        <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if ((state != RUN) || !enable) begin
                // Held clear so the next RUN entry starts a fresh window;
                // a partial window being abandoned is simply dropped here.
                presc     <= PRESC_TOP;
                win_rem   <= window_len;
                spike_cnt <= '0;
                ovf_pend  <= 1'b0;
                isi_cnt   <= '0;
                have_prev <= 1'b0;
            end else begin
                presc <= tick ? PRESC_TOP : presc - PW'(1);

                if (win_end) begin
                    rate       <= cnt_next;
                    ovf        <= ovf_next;
                    rate_valid <= 1'b1;
                    spike_cnt  <= '0;
                    ovf_pend   <= 1'b0;
                    win_rem    <= window_len;
                end else begin
                    spike_cnt <= cnt_next;
                    ovf_pend  <= ovf_next;
                    if (tick) begin
                        win_rem <= win_rem - SNN_W'(1);
                    end
                end

                // A spike on a tick cycle wins: the tick is not counted.
                if (spike_evt) begin
                    if (have_prev) begin
                        isi       <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                    isi_cnt   <= '0;
                    have_prev <= 1'b1;
                end else if (tick) begin
                    isi_cnt <= sat_inc(isi_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder with PRESCALE=4: a table of whole-window rate
// cases, hand sequences for reset, ISI, coincidence, wide pulses, window_len
// changes and disable, then random traffic. A timestamp-style reference model
// checks every output on every cycle throughout.
module tb_spike_rate_decoder;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spike_in = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic [7:0] rate;
    logic       rate_valid;
    logic       ovf;
    logic [7:0] isi;
    logic       isi_valid;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;
    int iv_cnt = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .window_len (window_len),
        .rate       (rate),
        .rate_valid (rate_valid),
        .ovf        (ovf),
        .isi        (isi),
        .isi_valid  (isi_valid)
    );

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // ---------------- reference model ----------------
    // Spikes are rising edges of the pin as seen at clock edges, acted on three
    // edges later. Time is counted in RUN cycles since entry; a tick falls on
    // every P-th cycle. Rate is a plain integer count clipped at 255; ISI is a
    // difference of running tick totals.
    logic [3:0] m_hist = '0;
    bit         m_run = 0;
    bit         m_have = 0;
    int         m_n = 0, m_win = 0, m_wt = 0, m_cnt = 0, m_ticks = 0, m_mark = 0;
    bit         m_evt, m_tk;
    logic [7:0] m_rate = '0, m_isi = '0;
    logic       m_rv = 0, m_ovf = 0, m_iv = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist = '0; m_run = 0; m_have = 0;
            m_n = 0; m_win = 0; m_wt = 0; m_cnt = 0; m_ticks = 0; m_mark = 0;
            m_rate = '0; m_isi = '0; m_rv = 0; m_ovf = 0; m_iv = 0;
        end else begin
            m_rv = 0;
            m_iv = 0;
            m_evt = m_hist[2] & ~m_hist[3];
            m_hist = {m_hist[2:0], spike_in};
            if (!m_run) begin
                if (enable && window_len != 0) begin
                    m_run = 1; m_n = 0; m_win = window_len; m_wt = 0;
                    m_cnt = 0; m_ticks = 0; m_have = 0;
                end
            end else if (!enable) begin
                m_run = 0;
            end else begin
                m_tk = ((m_n % P) == P - 1);
                m_n++;
                if (m_evt) begin
                    m_cnt++;
                    if (m_have) begin
                        m_isi = 8'(min255(m_ticks - m_mark));
                        m_iv = 1;
                    end
                    m_have = 1;
                    m_mark = m_ticks + (m_tk ? 1 : 0);
                end
                if (m_tk) begin
                    m_ticks++;
                    m_wt++;
                    if (m_wt == m_win) begin
                        m_rate = 8'(min255(m_cnt));
                        m_ovf = (m_cnt > 255);
                        m_rv = 1;
                        m_cnt = 0; m_wt = 0; m_win = window_len;
                        if (window_len == 0) m_run = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus pulse counters.
    always @(negedge clk) begin
        checks++;
        if ({rate, rate_valid, ovf, isi, isi_valid} !== {m_rate, m_rv, m_ovf, m_isi, m_iv}) begin
            errors++;
            $display("FAIL model @%0t: got rate=%0d rv=%0b ovf=%0b isi=%0d iv=%0b, expected rate=%0d rv=%0b ovf=%0b isi=%0d iv=%0b",
                     $time, rate, rate_valid, ovf, isi, isi_valid, m_rate, m_rv, m_ovf, m_isi, m_iv);
        end
        if (rate_valid) rv_cnt++;
        if (isi_valid) iv_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int width, input int period);
        spike_in = 1'b1;
        step(width);
        spike_in = 1'b0;
        step(period - width);
    endtask

    task automatic restart(input int wl);
        enable = 1'b0;
        step(2);
        window_len = 8'(wl);
        enable = 1'b1;
    endtask

    // Returns the number of edges until rate_valid is seen, or -1 on timeout.
    task automatic wait_rate(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            step(1);
            if (rate_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    typedef struct {
        int wl;
        int nspk;
        int gap;
        int exp_rate;
        int exp_ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c1, c2, rv0, iv0, w;

        tbl[0] = '{10, 7, 5, 7, 0};
        tbl[1] = '{1, 1, 2, 1, 0};
        tbl[2] = '{3, 0, 2, 0, 0};
        tbl[3] = '{20, 12, 3, 12, 0};
        tbl[4] = '{255, 300, 2, 255, 1};

        #1 rst_n = 1'b0;
        step(3);
        check("reset_rate", rate, 0);
        check("reset_isi", isi, 0);
        rst_n = 1'b1;
        step(2);

        // Whole-window rate vectors
        for (int k = 0; k < 5; k++) begin
            restart(tbl[k].wl);
            for (int s = 0; s < tbl[k].nspk; s++) pulse(1, tbl[k].gap);
            wait_rate(1200, c);
            check($sformatf("tbl%0d_seen", k), (c > 0) ? 1 : 0, 1);
            check($sformatf("tbl%0d_rate", k), rate, tbl[k].exp_rate);
            check($sformatf("tbl%0d_ovf", k), ovf, tbl[k].exp_ovf);
        end

        // Window after a saturated one starts clean
        for (int s = 0; s < 3; s++) pulse(1, 5);
        wait_rate(1200, c);
        check("sat_next_rate", rate, 3);
        check("sat_next_ovf", ovf, 0);

        // ISI: 40-cycle spacing is 10 ticks; first spike gives no pulse
        restart(255);
        iv0 = iv_cnt;
        pulse(1, 40);
        check("isi_first_nopulse", iv_cnt - iv0, 0);
        for (int s = 0; s < 3; s++) pulse(1, 40);
        check("isi_pulses", iv_cnt - iv0, 3);
        check("isi_value", isi, 10);
        pulse(1, 2000);
        pulse(1, 10);
        check("isi_sat", isi, 255);

        // Reset mid-RUN clears outputs at once; fresh window after release
        restart(5);
        pulse(1, 3);
        pulse(1, 3);
        wait_rate(40, c);
        check("rst_pre_rate", rate, 2);
        step(8);
        rst_n = 1'b0;
        #1;
        check("rst_async_rate", rate, 0);
        check("rst_async_isi", isi, 0);
        check("rst_async_flags", {rate_valid, ovf, isi_valid}, 0);
        step(2);
        rst_n = 1'b1;
        wait_rate(40, c);
        check("rst_first_window", (c >= 20 && c <= 22) ? 1 : 0, 1);

        // Spike coincident with the window-ending tick lands in that window
        restart(2);
        step(5);
        pulse(1, 1);
        wait_rate(20, c);
        check("coinc_rate", rate, 1);
        wait_rate(20, c);
        check("coinc_next_rate", rate, 0);

        // A 50-cycle high level is one spike
        restart(20);
        spike_in = 1'b1;
        step(50);
        spike_in = 1'b0;
        wait_rate(100, c);
        check("wide_rate", rate, 1);

        // window_len change mid-window takes effect at the next window
        restart(10);
        step(3);
        window_len = 8'd3;
        wait_rate(60, c1);
        check("wl_change_first", (c1 >= 36 && c1 <= 39) ? 1 : 0, 1);
        wait_rate(30, c2);
        check("wl_change_second", c2, 12);

        // Disable mid-window discards it; re-enable runs a full window
        restart(10);
        pulse(1, 5);
        pulse(1, 5);
        wait_rate(60, c);
        check("dis_pre_rate", rate, 2);
        pulse(1, 4);
        pulse(1, 4);
        pulse(1, 4);
        rv0 = rv_cnt;
        enable = 1'b0;
        step(60);
        check("dis_no_valid", rv_cnt - rv0, 0);
        check("dis_rate_hold", rate, 2);
        enable = 1'b1;
        wait_rate(60, c);
        check("dis_full_window", (c >= 40 && c <= 42) ? 1 : 0, 1);
        check("dis_reenable_rate", rate, 0);

        // Random traffic against the model
        rv0 = rv_cnt;
        restart(1 + $urandom_range(0, 7));
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0: window_len = 8'(1 + $urandom_range(0, 7));
                1: begin
                    enable = 1'b0;
                    step(1 + $urandom_range(0, 3));
                    enable = 1'b1;
                end
                default: begin
                    w = 1 + $urandom_range(0, 2);
                    pulse(w, w + 1 + $urandom_range(0, 10));
                end
            endcase
        end
        enable = 1'b0;
        step(3);
        check("rand_windows", (rv_cnt > rv0) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side counterpart to the LIF neuron core: it accepts a spike train on one pin and decodes it into numbers. It reports a windowed firing rate and the most recent inter-spike interval (ISI) as 8-bit values. Typical uses:
- measuring the output of an on-chip neuron looped back through a `uio` pin;
- measuring the output of an off-chip neuron;
- feeding the decoded rate back as stimulus current.

## Interface
Parameters:
- `PRESCALE`, default 256: clock cycles per time tick; legal range ≥ 2.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `spike_in` input 1: raw spike pin, asynchronous to `clk`.
- `enable` input 1: level; 1 = decode, 0 = idle.
- `window_len` input 8: rate window length in ticks; 0 = disabled.
- `rate` output 8: spike count of the last completed window, saturating.
- `rate_valid` output 1: one-cycle pulse when `rate` updates.
- `ovf` output 1: the last completed window saturated at 255.
- `isi` output 8: ticks between the last two spikes, saturating at 255.
- `isi_valid` output 1: one-cycle pulse when `isi` updates.

## Operation
- **Input path:** `spike_in` passes through a 2-FF synchronizer. A rising-edge detect on the synchronized signal produces `spike_evt`, a one-cycle event.
  - A level held high counts as one spike.
  - Pulses shorter than one `clk` period may be missed.
- **Prescaler:**
  - Counts 0..`PRESCALE`-1 and asserts `tick` on the cycle it wraps.
  - Cleared while in IDLE.
- **State machine, two states:**
  - IDLE: entered on reset, or whenever `enable`=0 or `window_len`=0.
  - RUN: entered from IDLE when `enable`=1 and `window_len`≠0.
- **Entering RUN:**
  - Latch `win_q` from `window_len`; changes to `window_len` mid-window take effect at the next window start.
  - Clear the spike counter, tick counter, prescaler and `have_prev`.
- **Window, in RUN:**
  - `spike_evt` increments the 8-bit spike counter, saturating at 255.
  - Any increment attempted at 255 sets the window's `ovf_pend`.
  - `tick` increments the tick counter.
  - When the tick counter reaches `win_q` on a `tick`, the window ends, in the same cycle:
    - `rate` ← the count, including a `spike_evt` in that same cycle;
    - `ovf` ← `ovf_pend`;
    - `rate_valid` pulses;
    - the counters and `ovf_pend` clear;
    - `win_q` re-latches from `window_len`; if `window_len` is 0 the block goes to IDLE.
- **ISI, in RUN:**
  - The 8-bit ISI counter increments on `tick` and saturates at 255.
  - On `spike_evt` with `have_prev`=1: `isi` ← counter, `isi_valid` pulses, counter clears.
  - On `spike_evt` with `have_prev`=0: no pulse; counter clears and `have_prev` is set.
  - If `spike_evt` and `tick` coincide, the spike wins: the captured value excludes that tick, and the counter clears to 0.
- **Leaving RUN on `enable`=0:**
  - The partial window is discarded; no `rate_valid`.
  - `rate`, `isi` and `ovf` hold their last values.
- **Reset:** all outputs and state are 0; the state is IDLE.

## Timing
- Latency from a `spike_in` rise to `spike_evt` is 3 `clk` edges: 2 synchronizer stages plus 1 edge-detect stage.
- `isi_valid` is registered and asserts 1 cycle after `spike_evt`.
- `rate_valid` asserts 1 cycle after the window-ending `tick`.
- The pulse outputs are high for exactly one cycle, with no handshake. A consumer must sample on the pulse; values stay stable until the next pulse.
- All outputs are registered, with no combinational path from inputs to outputs.
- The first window ends `win_q` × `PRESCALE` cycles after RUN entry, give or take 1 cycle.
- Asynchronous reset asserted mid-window clears the state immediately. On release, decoding restarts with a fresh window.

## Structure
- Shared package `snn_pkg`:
  - state enum `dec_state_t` {IDLE, RUN};
  - `CNT_MAX` = 8'hFF;
  - spike/current width constant `SNN_W` = 8, shared with the neuron core.
- Sub-module `spike_sync`: 2-FF synchronizer plus rising-edge detect, reusable for any asynchronous pin.
- The top level is the prescaler, state machine, window counter and ISI counter.

## Test plan
All scenarios use `PRESCALE`=4.
- **Reset:** assert `rst_n`=0 mid-RUN → all outputs are 0 immediately; after release with `enable`=1 and `window_len`=5, the first `rate_valid` arrives about 20 cycles later.
- **Rate:** `window_len`=10, 7 clean spikes spaced 5 cycles apart → `rate`=7, `ovf`=0, one `rate_valid` pulse.
- **Saturation:** `window_len`=255, 300 spikes at 1 per 2 cycles → `rate`=255, `ovf`=1. The next window, with 3 spikes, gives `rate`=3, `ovf`=0.
- **ISI:**
  - spikes 40 cycles apart → first spike gives no `isi_valid`, then `isi`=10 on each following spike;
  - a gap of 2000 cycles → `isi`=255.
- **Edge cases:**
  - a spike coincident with the window-ending `tick` is counted in the closing window;
  - a 50-cycle-wide high level counts as one spike;
  - `window_len` changed from 10 to 3 mid-window → that window still ends after 10 ticks, and the next ends after 3.
- **Disable:** drop `enable` mid-window → no `rate_valid`; `rate` holds its previous value; re-enabling starts a full window.
